// File: rtl/fs_cmd_parser.sv
// fs_cmd_parser: framed register read/write command decoder for the fast-serial path.
// Frame: 0xA5, CMD ('W' 0x57 / 'R' 0x52), ADDR, DATA (writes only); one response byte per frame.
// R0..R2 read/write (R0 drives o_led), R3 read-only VERSION.
// Optional macro FS_CMD_TIMEOUT_EN: inter-byte timeout that abandons a partial frame.
module fs_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  VERSION        = 8'h01
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_ready,
  input  logic       i_tx_busy,
  output logic [7:0] o_tx_data,
  output logic       o_tx_write,
  output logic [7:0] o_led,
  output logic       o_err
);

  localparam logic [7:0] SYNC  = 8'hA5;
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  // Elaboration-time guard on the timeout range
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 32'h00FF_FFFF) begin : g_bad_timeout
    $error("fs_cmd_parser: TIMEOUT_CYCLES out of range 1..2^24-1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_EXEC,
    S_TX_REQ,
    S_TX_WAIT
  } state_t;

  state_t     state;
  logic       rx_prev;
  logic [7:0] cmd_q;
  logic [7:0] addr_q;
  logic [7:0] data_q;
  logic [7:0] reg0;
  logic [7:0] reg1;
  logic [7:0] reg2;

  logic       accept_c;
  logic       timeout_c;
  logic [7:0] resp_c;
  logic       wr_en_c;

  assign accept_c = i_rx_ready & ~rx_prev;
  assign o_led    = reg0;

`ifdef FS_CMD_TIMEOUT_EN
  localparam int unsigned CNT_W = 24;

  logic [CNT_W-1:0] to_cnt;
  logic             in_frame_c;

  assign in_frame_c = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA);
  assign timeout_c  = in_frame_c && !accept_c &&
                      (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Inter-byte silence counter; only runs inside a partial frame
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      to_cnt <= '0;
    end else if (!in_frame_c || accept_c || timeout_c) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Response selection for the frame held in cmd_q/addr_q
  always_comb begin
    resp_c  = NAK;
    wr_en_c = 1'b0;
    if (cmd_q == CMD_W && addr_q <= 8'd2) begin
      resp_c  = ACK;
      wr_en_c = 1'b1;
    end else if (cmd_q == CMD_R) begin
      case (addr_q)
        8'd0:    resp_c = reg0;
        8'd1:    resp_c = reg1;
        8'd2:    resp_c = reg2;
        8'd3:    resp_c = VERSION;
        default: resp_c = NAK;
      endcase
    end
  end

  // Frame parser, register file and transmit handshake
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      rx_prev    <= 1'b0;
      cmd_q      <= 8'h00;
      addr_q     <= 8'h00;
      data_q     <= 8'h00;
      reg0       <= 8'h00;
      reg1       <= 8'h00;
      reg2       <= 8'h00;
      o_tx_data  <= 8'h00;
      o_tx_write <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      rx_prev <= i_rx_ready;
      o_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept_c && i_rx_data == SYNC) begin
            state <= S_CMD;
          end
        end
        S_CMD: begin
          if (accept_c) begin
            cmd_q <= i_rx_data;
            state <= S_ADDR;
          end else if (timeout_c) begin
            o_err <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_ADDR: begin
          if (accept_c) begin
            addr_q <= i_rx_data;
            state  <= (cmd_q == CMD_W) ? S_DATA : S_EXEC;
          end else if (timeout_c) begin
            o_err <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (accept_c) begin
            data_q <= i_rx_data;
            state  <= S_EXEC;
          end else if (timeout_c) begin
            o_err <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_EXEC: begin
          o_err      <= accept_c;
          o_tx_data  <= resp_c;
          o_tx_write <= 1'b1;
          if (wr_en_c) begin
            case (addr_q[1:0])
              2'd0:    reg0 <= data_q;
              2'd1:    reg1 <= data_q;
              default: reg2 <= data_q;
            endcase
          end
          state <= S_TX_REQ;
        end
        S_TX_REQ: begin
          o_err <= accept_c;
          if (i_tx_busy) begin
            o_tx_write <= 1'b0;
            state      <= S_TX_WAIT;
          end
        end
        S_TX_WAIT: begin
          o_err <= accept_c;
          if (!i_tx_busy) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fs_cmd_parser.sv
// Bench for fs_cmd_parser: frame-level reference model plus directed and random frames.
module tb_fs_cmd_parser;

  localparam int unsigned TO = 50;
`ifdef FS_CMD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic       tx_write;
  logic [7:0] led;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  fs_cmd_parser #(.TIMEOUT_CYCLES(TO), .VERSION(8'h01)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rx_data  (rx_data),
    .i_rx_ready (rx_ready),
    .i_tx_busy  (tx_busy),
    .o_tx_data  (tx_data),
    .o_tx_write (tx_write),
    .o_led      (led),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: frame bytes collected in a queue ----------------
  typedef enum int {M_PARSE, M_EXEC, M_REQ, M_WAIT} mph_t;
  mph_t       m_phase;
  logic [7:0] m_frame[$];
  logic [7:0] m_regs[3];
  int         m_idle;
  logic       m_prev;
  logic       m_acc;
  int         m_need;
  logic [7:0] e_data, e_led;
  logic       e_write, e_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = M_PARSE;
      m_frame.delete();
      for (int i = 0; i < 3; i++) m_regs[i] = 8'h00;
      m_idle = 0; m_prev = 1'b0;
      e_data = 8'h00; e_write = 1'b0; e_err = 1'b0; e_led = 8'h00;
    end else begin
      m_acc  = rx_ready && !m_prev;
      m_prev = rx_ready;
      e_err  = 1'b0;
      case (m_phase)
        M_PARSE: begin
          if (m_acc) begin
            if (m_frame.size() != 0 || rx_data == 8'hA5) m_frame.push_back(rx_data);
            m_idle = 0;
            m_need = (m_frame.size() >= 2 && m_frame[1] == 8'h57) ? 4 : 3;
            if (m_frame.size() == m_need) m_phase = M_EXEC;
          end else if (TO_EN && m_frame.size() != 0) begin
            m_idle++;
            if (m_idle == TO) begin
              m_frame.delete(); m_idle = 0; e_err = 1'b1;
            end
          end
        end
        M_EXEC: begin
          if (m_acc) e_err = 1'b1;
          if (m_frame[1] == 8'h57 && m_frame[2] < 8'd3) begin
            m_regs[m_frame[2]] = m_frame[3]; e_data = 8'h06;
          end else if (m_frame[1] == 8'h52 && m_frame[2] < 8'd3) e_data = m_regs[m_frame[2]];
          else if (m_frame[1] == 8'h52 && m_frame[2] == 8'd3) e_data = 8'h01;
          else e_data = 8'h15;
          e_write = 1'b1;
          m_phase = M_REQ;
        end
        M_REQ: begin
          if (m_acc) e_err = 1'b1;
          if (tx_busy) begin e_write = 1'b0; m_phase = M_WAIT; end
        end
        default: begin
          if (m_acc) e_err = 1'b1;
          if (!tx_busy) begin m_phase = M_PARSE; m_frame.delete(); end
        end
      endcase
      e_led = m_regs[0];
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    n_cmp++;
    if ({tx_write, tx_data, led, err} !== {e_write, e_data, e_led, e_err}) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL cycle_cmp t=%0t got write=%b data=%h led=%h err=%b want write=%b data=%h led=%h err=%b",
                 $time, tx_write, tx_data, led, err, e_write, e_data, e_led, e_err);
    end
  end

  // Response capture and error-pulse counter
  logic       w_prev = 1'b0;
  logic [7:0] cap_resp = 8'h00, cap_model = 8'h00;
  int         cap_cnt = 0, err_cnt = 0;
  always @(negedge clk) begin
    if (tx_write && !w_prev) begin cap_resp = tx_data; cap_model = e_data; cap_cnt++; end
    w_prev = tx_write;
    if (err) err_cnt++;
  end

  // Transmitter stand-in: busy after busy_delay cycles, for busy_len cycles
  int busy_delay = 1, busy_len = 2;
  initial begin
    forever begin
      @(negedge clk);
      if (tx_write === 1'b1 && rst_n) begin
        repeat (busy_delay) @(negedge clk);
        #1 tx_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(negedge clk); #1;
    rx_data = b; rx_ready = 1'b1;
    repeat (hold) @(negedge clk);
    #1 rx_ready = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data);
    send_byte(8'hA5, 1, 0);
    send_byte(cmd, 1, 0);
    send_byte(addr, 1, 0);
    if (cmd == 8'h57) send_byte(data, 1, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(m_phase == M_PARSE && m_frame.size() == 0)) begin
      @(negedge clk); n++;
      if (n > 400) begin
        n_cmp++; n_bad++;
        $display("FAIL wait_idle: parser not idle after %0d cycles", n);
        return;
      end
    end
    @(negedge clk);
  endtask

  task automatic expect_resp(input string name, input int c0, input logic [7:0] exp);
    int n = 0;
    while (cap_cnt == c0 && n < 200) begin @(negedge clk); #2; n++; end
    check({name, "_dut"}, cap_resp, exp);
    check({name, "_model"}, cap_model, exp);
    wait_idle();
  endtask

  initial begin
    int c0, e0;
    logic [7:0] cmd, addr, data, junk;
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, e0, kind, n;
    logic [7:0] cmd, addr, data, junk;
    // Reset values
    repeat (3) @(negedge clk);
    #2;
    check("rst_tx_write", tx_write, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_led", led, 8'h00);
    check("rst_err", err, 1'b0);
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write R0 = 3C: led updates two edges after the last byte
    c0 = cap_cnt;
    send_byte(8'hA5, 1, 0); send_byte(8'h57, 1, 0); send_byte(8'h00, 1, 0);
    send_byte(8'h3C, 1, 0);
    check("led_before", led, 8'h00);
    @(negedge clk); #2;
    check("led_after", led, 8'h3C);
    check("model_led", e_led, 8'h3C);
    check("write_req", tx_write, 1'b1);
    expect_resp("ack", c0, 8'h06);

    // Read-back and version
    c0 = cap_cnt; send_frame(8'h52, 8'h00, 8'h00); expect_resp("read_r0", c0, 8'h3C);
    c0 = cap_cnt; send_frame(8'h52, 8'h03, 8'h00); expect_resp("read_ver", c0, 8'h01);

    // NAK cases
    c0 = cap_cnt; send_frame(8'h57, 8'h03, 8'hFF); expect_resp("nak_w3", c0, 8'h15);
    c0 = cap_cnt; send_frame(8'h52, 8'h03, 8'h00); expect_resp("ver_kept", c0, 8'h01);
    c0 = cap_cnt; send_frame(8'h57, 8'h09, 8'h11); expect_resp("nak_addr", c0, 8'h15);
    c0 = cap_cnt; send_frame(8'h41, 8'h00, 8'h00); expect_resp("nak_cmd", c0, 8'h15);
    check("led_kept", led, 8'h3C);

    // Handshake: busy held low for 20 cycles
    busy_delay = 20;
    c0 = cap_cnt; send_frame(8'h57, 8'h01, 8'h5A);
    n = 0;
    while (cap_cnt == c0 && n < 50) begin @(negedge clk); #2; n++; end
    repeat (19) @(negedge clk);
    #2;
    check("hold_write", tx_write, 1'b1);
    check("hold_data", tx_data, 8'h06);
    wait_idle();
    busy_delay = 1;

    // Byte dropped during TX_WAIT
    busy_len = 8;
    c0 = cap_cnt; e0 = err_cnt;
    send_frame(8'h52, 8'h01, 8'h00);
    n = 0;
    while (tx_busy !== 1'b1 && n < 50) begin @(negedge clk); #2; n++; end
    send_byte(8'hA5, 1, 0);
    repeat (3) @(negedge clk);
    #2;
    check("drop_err", err_cnt - e0, 1);
    check("drop_resp", cap_resp, 8'h5A);
    wait_idle();
    busy_len = 2;
    c0 = cap_cnt; send_frame(8'h52, 8'h00, 8'h00); expect_resp("after_drop", c0, 8'h3C);

    // Sync hunt with ready held high 5 cycles per byte
    c0 = cap_cnt;
    send_byte(8'h00, 5, 1); send_byte(8'hFF, 5, 1); send_byte(8'hA5, 5, 1);
    send_byte(8'h52, 5, 1); send_byte(8'h01, 5, 1);
    expect_resp("hunt", c0, 8'h5A);

    // Inter-byte timeout
    c0 = cap_cnt; e0 = err_cnt;
    send_byte(8'hA5, 1, 0); send_byte(8'h57, 1, 0);
    repeat (60) @(negedge clk);
    #2;
    check("to_err", err_cnt - e0, TO_EN ? 1 : 0);
    check("to_no_tx", cap_cnt - c0, 0);
    if (TO_EN) begin
      c0 = cap_cnt; send_frame(8'h52, 8'h00, 8'h00); expect_resp("to_next", c0, 8'h3C);
    end else begin
      c0 = cap_cnt; send_byte(8'h02, 1, 0); send_byte(8'h77, 1, 0);
      expect_resp("to_wait", c0, 8'h06);
      c0 = cap_cnt; send_frame(8'h52, 8'h02, 8'h00); expect_resp("to_r2", c0, 8'h77);
    end

    // Mid-frame reset clears registers
    send_byte(8'hA5, 1, 0); send_byte(8'h57, 1, 0); send_byte(8'h01, 1, 0);
    @(negedge clk); #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("mid_rst_led", led, 8'h00);
    check("mid_rst_write", tx_write, 1'b0);
    @(negedge clk); #1 rst_n = 1'b1;
    c0 = cap_cnt; send_frame(8'h52, 8'h01, 8'h00); expect_resp("rst_r1", c0, 8'h00);

    // Random frames, garbage and dropped bytes
    for (int it = 0; it < 200; it++) begin
      busy_delay = $urandom_range(0, 4);
      busy_len   = $urandom_range(1, 4);
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hA5) junk = 8'h00;
        send_byte(junk, $urandom_range(1, 3), $urandom_range(0, 2));
      end else begin
        case ($urandom_range(0, 4))
          0, 1:    cmd = 8'h57;
          2, 3:    cmd = 8'h52;
          default: cmd = 8'($urandom_range(0, 255));
        endcase
        addr = 8'($urandom_range(0, 4));
        data = 8'($urandom_range(0, 255));
        send_byte(8'hA5, $urandom_range(1, 4), $urandom_range(0, 3));
        send_byte(cmd, $urandom_range(1, 4), $urandom_range(0, 3));
        send_byte(addr, $urandom_range(1, 4), $urandom_range(0, 3));
        if (cmd == 8'h57) send_byte(data, $urandom_range(1, 4), 0);
        if (kind == 9) begin
          junk = 8'($urandom_range(0, 255));
          if (junk == 8'hA5) junk = 8'h5A;
          send_byte(junk, 1, 0);
        end
      end
      wait_idle();
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fs_cmd_parser.md
# fs_cmd_parser

Byte-level command decoder between `rx_fastserial` and `tx_fastserial` in the FTDI fast-serial path, replacing the plain echo loop. It consumes received bytes, parses fixed-length framed register read/write commands against a small register file, and issues one response byte per frame to the transmitter. Register 0 drives the board LEDs.

## Interface
- `TIMEOUT_CYCLES`, default 100000: inter-byte timeout in `i_clk` cycles (1 ms at 100 MHz); range 1..2^24-1.
- `VERSION`, default 8'h01: constant value returned by reads of register 3.

- `i_clk`  in  1  fast-serial system clock (100 MHz PLL output); the only clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_rx_data`  in  8  received byte from `rx_fastserial`; valid when `i_rx_ready` rises.
- `i_rx_ready`  in  1  receive-ready from `rx_fastserial`; level or pulse, edge-detected internally.
- `i_tx_busy`  in  1  busy from `tx_fastserial`.
- `o_tx_data`  out  8  response byte to `tx_fastserial`.
- `o_tx_write`  out  1  transmit request to `tx_fastserial`.
- `o_led`  out  8  contents of register 0.
- `o_err`  out  1  one-cycle pulse on protocol error (timeout, byte dropped during response).

## Operation
- Byte accept: a byte is accepted on the cycle where `i_rx_ready`=1 and its registered previous value was 0. `i_rx_data` is sampled that cycle.
- Frame: `0xA5` sync, CMD, ADDR, then DATA only for writes.
  - CMD `0x57` ('W') is a write; CMD `0x52` ('R') is a read.
- Registers: R0..R2 are read/write, 8 bits, reset to 0x00. R3 is read-only and returns `VERSION`.
- States: `IDLE` → `CMD` → `ADDR` → (`DATA` if W) → `EXEC` → `TX_REQ` → `TX_WAIT` → `IDLE`.
  - `IDLE`: discard any accepted byte ≠ 0xA5, with no error. 0xA5 → `CMD`.
  - `CMD`: accept any byte. An unknown CMD is still carried to `ADDR`/`EXEC` and produces a NAK.
  - `EXEC` (one cycle), response selection:
    - W with ADDR ≤ 2: write DATA, response `0x06` (ACK).
    - R with ADDR ≤ 3: response = register value.
    - Otherwise (ADDR > 3, W to 3, unknown CMD): response `0x15` (NAK), no register change.
  - `TX_REQ`: hold `o_tx_write`=1 with `o_tx_data` stable until `i_tx_busy`=1 is sampled. Then drop `o_tx_write` and go to `TX_WAIT`.
  - `TX_WAIT`: stay until `i_tx_busy`=0, then go to `IDLE`.
- Bytes accepted in `EXEC`/`TX_REQ`/`TX_WAIT` are dropped and `o_err` pulses.
- Mid-operation reset: all state returns to `IDLE`, registers go to 0x00, and any pending response is abandoned.

## Timing
- Reset values: `o_tx_data`=0x00, `o_tx_write`=0, `o_led`=0x00, `o_err`=0, state `IDLE`, edge-detect register 0, timeout counter 0.
- Final byte accepted at edge N:
  - `EXEC` during cycle N+1; register write visible on `o_led` at N+2.
  - `o_tx_write`=1 from N+2.
- `o_tx_write` falls on the cycle after `i_tx_busy`=1 is first sampled. It is never reasserted before `i_tx_busy` has been sampled low.
- Back-to-back frames: the next sync byte is accepted only from `IDLE`, i.e. at the earliest the cycle after `i_tx_busy` is seen low.
- `o_err` is registered and lasts exactly one cycle per event.
- Simultaneous timeout and byte accept: the byte accept wins and the counter clears.

## Configuration
- `FS_CMD_TIMEOUT_EN` defined: a 24-bit counter runs in `CMD`/`ADDR`/`DATA` and clears on each accepted byte.
  - When it reaches `TIMEOUT_CYCLES`: state → `IDLE`, `o_err` pulses, no response is sent.
- Undefined: no counter is synthesized, and the parser waits indefinitely in a partial frame.

## Test plan
- Write: bytes A5,57,00,3C → `o_led`=0x3C two cycles after the last byte; `o_tx_write`=1 with `o_tx_data`=0x06, held until `i_tx_busy` rises.
- Read-back and version: A5,52,00 after the write → response 0x3C; A5,52,03 → response 0x01.
- NAK cases: A5,57,03,FF → 0x15 and R3 unchanged; A5,57,09,11 → 0x15; A5,41,00 → 0x15; registers unchanged in all cases.
- Handshake and drop: hold `i_tx_busy`=0 for 20 cycles after the request → `o_tx_write` stays 1 and `o_tx_data` stays stable. Send a byte during `TX_WAIT` → one-cycle `o_err`, byte ignored.
- Sync hunt and edge detect: bytes 00,FF,A5,52,01 with `i_rx_ready` held high for 5 cycles per byte → each byte accepted once; response = R1 value.
- Timeout (macro on, `TIMEOUT_CYCLES`=50): A5,57 then silence for 60 cycles → `o_err` pulse at cycle 50, no transmit. A following full frame parses normally. With the macro off → no `o_err`, parser still waiting in `ADDR`.
